// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - per-LED PWM display stage with linear comet-tail fade
// Optional LED_TRAIL_GAMMA_EN squares the level into the duty for a perceptual fade.
module led_trail_pwm #(
    parameter int N         = 8,
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [N-1:0]  leds_in,
    output logic [N-1:0]  pwm_out,
    output logic          busy
);
    localparam int MAX   = (1 << PWM_BITS) - 1;
    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX_V    = PWM_BITS'(MAX);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAX - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0]         cnt_q, cnt_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [N-1:0][PWM_BITS-1:0]  level_q, level_d;
    logic [N-1:0][PWM_BITS-1:0]  duty;
    logic [N-1:0]                pwm_q, pwm_d;
    logic                        tick;
    logic                        cnt_wrap;

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign tick     = cnt_wrap && (div_q == DIV_LAST);

    for (genvar i = 0; i < N; i++) begin : g_duty
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        assign sq      = level_q[i] * level_q[i];
        assign duty[i] = PWM_BITS'(sq / (2*PWM_BITS)'(MAX));
`else
        assign duty[i] = level_q[i];
`endif
    end

    always_comb begin
        cnt_d   = '0;
        div_d   = '0;
        level_d = '0;
        pwm_d   = '0;
        if (enable) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            div_d = div_q;
            if (cnt_wrap) begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                // Reload has priority over decay, so a lit LED never dims on a tick.
                if (leds_in[i]) begin
                    level_d[i] = MAX_V;
                end else if (tick && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - 1'b1;
                end else begin
                    level_d[i] = level_q[i];
                end
                pwm_d[i] = (duty[i] > cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            level_q <= '0;
            pwm_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
    assign busy    = |level_q;

endmodule
